arp_rx_parser: RTL and testbench
================================

# arp_rx_parser

Word-serial ARP frame parser sitting directly upstream of the ARP responder in the parser path. It consumes the 32-bit ARP payload stream delivered by the EtherType dispatcher, with the Ethernet header already stripped. It validates the fixed header fields and checks the target IP against the local address. For each valid ARP Request it presents the requester's MAC/IP to the responder over a valid/ready handshake, and it keeps saturating counters for malformed and overflowed frames.

## Interface
- `LOCAL_IP`, default 32'hC0A8_010A: local IPv4 address; target protocol address (TPA) must match it.
- `CNT_W`, default 16: width of the statistics counters.

- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_arp_data` in 32: payload word, big-endian, first byte in [31:24].
- `i_arp_valid` in 1: data beat valid. There is no backpressure; the block is always ready.
- `i_arp_last` in 1: final beat of the frame; qualified by `i_arp_valid`.
- `o_req_valid` out 1: request record valid; held until `i_req_ready`.
- `i_req_ready` in 1: responder accepts the record.
- `o_req_sha` out 48: sender hardware address (requester MAC).
- `o_req_spa` out 32: sender protocol address (requester IP).
- `o_err_cnt` out CNT_W: count of malformed frames, saturating.
- `o_ovf_cnt` out CNT_W: count of valid requests dropped because the output slot was full, saturating.

## Operation
- Word layout, indexed from the first beat (W0…W6):
  - W0: HTYPE[31:16], PTYPE[15:0]
  - W1: HLEN[31:24], PLEN[23:16], OPER[15:0]
  - W2: SHA[47:16]
  - W3: SHA[15:0], SPA[31:16]
  - W4: SPA[15:0], THA[47:32]
  - W5: THA[31:0]
  - W6: TPA
  - W7 onward: padding, ignored.
- A 3-bit word counter counts accepted beats and saturates at 7. It resets to 0 after every last beat.
- The `bad` flag is set if any of the following holds:
  - W0 ≠ 32'h0001_0800.
  - W1[31:16] ≠ 16'h0604.
  - A last beat arrives at word index < 6 (runt frame).
- The `is_req` flag is set when OPER == 16'h0001. The `tpa_hit` flag is set when W6 == LOCAL_IP.
- SHA and SPA are captured into shadow registers on W2, W3 and W4.
- The FSM has three states:
  - S_HDR (W0–W1): checks the header fields.
  - S_BODY (W2–W6): captures addresses and compares TPA.
  - S_PAD (W7 onward, or any beat after `bad` is set): discards data until the last beat.
  - Any last beat returns the FSM to S_HDR.
- Frame disposition is decided on the last beat:
  - If `bad`: `o_err_cnt` +1, no output.
  - Else if `is_req` && `tpa_hit`: request emitted (see below).
  - Else: silently ignored. This covers replies and foreign TPAs; no counter changes.
- Output slot:
  - The slot holds one record.
  - If the slot is empty, or is being drained in the same cycle (`o_req_valid` && `i_req_ready`), the shadow registers are loaded into the slot.
  - Otherwise the record is dropped and `o_ovf_cnt` +1.
- A single-beat frame (`i_arp_last` on W0) is a runt: error count +1.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset values: `o_req_valid` = 0, `o_req_sha` = 0, `o_req_spa` = 0, `o_err_cnt` = 0, `o_ovf_cnt` = 0; FSM in S_HDR; word counter = 0.
- Reset asserted mid-frame discards the partial frame. The first beat after release is W0.
- Latency: `o_req_valid` rises on the clock edge after the last beat is sampled. Minimum frame is 7 beats, so there is 1 cycle from the last beat to valid.
- `o_req_sha` and `o_req_spa` are stable while `o_req_valid` is high. They change only on load.
- Handshake completes on the cycle where `o_req_valid` && `i_req_ready`. `o_req_valid` falls on the next edge unless a new record is loaded on that same edge.
- Counter updates are visible 1 cycle after the deciding last beat.
- Idle cycles (`i_arp_valid` = 0) inside a frame are permitted and do not change state.

## Structure
- Package `arp_pkg` holds:
  - constants ARP_HTYPE_ETH = 16'h0001, ARP_PTYPE_IPV4 = 16'h0800, ARP_HLEN = 8'd6, ARP_PLEN = 8'd4, ARP_OP_REQ = 16'h0001, ARP_OP_REP = 16'h0002;
  - the FSM state enum;
  - a packed struct `arp_req_t` {sha[47:0], spa[31:0]}, shared with the responder.
- One sub-module, `sat_counter #(W)`, with inc, cnt, clk and rst_n; instantiated twice.

## Test plan
- Valid request, frame SHA 02:00:00:00:00:01, SPA C0A8_0102, TPA C0A8_010A, 7 beats → `o_req_valid` 1 cycle after the last beat, SHA 48'h0200_0000_0001, SPA 32'hC0A8_0102; counters stay 0.
- Same request padded to 12 beats, with 2 idle gaps mid-frame, and `i_req_ready` held low for 5 cycles → valid held for 5 cycles with stable data, then drops 1 cycle after ready.
- OPER = 2, and separately a TPA of C0A8_0199 → no `o_req_valid`, `o_err_cnt` = 0.
- W0 = 32'h0006_0800, then a 4-beat runt, then W1 = 32'h0804_0001 → `o_err_cnt` = 3, no output; the following valid frame is still parsed correctly.
- Two back-to-back valid requests with ready low → first record held, `o_ovf_cnt` = 1. Repeat with ready high on the second frame's decision cycle → no drop, second record loaded.
- Assert `rst_n` low at W4 of a valid frame → outputs 0; the next full frame emits normally. Force 2^CNT_W + 3 malformed frames (or use CNT_W = 2) → `o_err_cnt` holds at all-ones.

Source files
------------

// File: rtl/arp_pkg.sv
// Shared ARP constants, parser state encoding and the request record handed to the responder.
package arp_pkg;

  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN       = 8'd6;
  localparam logic [7:0]  ARP_PLEN       = 8'd4;
  localparam logic [15:0] ARP_OP_REQ     = 16'h0001;
  localparam logic [15:0] ARP_OP_REP     = 16'h0002;

  // Word indices within the ARP payload
  localparam logic [2:0] WIDX_W0     = 3'd0;
  localparam logic [2:0] WIDX_W1     = 3'd1;
  localparam logic [2:0] WIDX_SHA_HI = 3'd2;
  localparam logic [2:0] WIDX_MID    = 3'd3;
  localparam logic [2:0] WIDX_SPA_LO = 3'd4;
  localparam logic [2:0] WIDX_TPA    = 3'd6;
  localparam logic [2:0] WIDX_MAX    = 3'd7;

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_BODY = 2'd1,
    S_PAD  = 2'd2
  } arp_state_e;

  typedef struct packed {
    logic [47:0] sha;
    logic [31:0] spa;
  } arp_req_t;

  function automatic logic arp_w0_ok(input logic [31:0] w);
    return w == {ARP_HTYPE_ETH, ARP_PTYPE_IPV4};
  endfunction

  function automatic logic arp_w1_ok(input logic [31:0] w);
    return w[31:16] == {ARP_HLEN, ARP_PLEN};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/arp_rx_parser.sv
// Word-serial ARP payload parser: validates the header, matches TPA against LOCAL_IP and
// hands requester MAC/IP to the responder through a one-entry valid/ready slot.
module arp_rx_parser
  import arp_pkg::*;
#(
  parameter logic [31:0] LOCAL_IP = 32'hC0A8_010A,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      i_arp_data,
  input  logic             i_arp_valid,
  input  logic             i_arp_last,
  output logic             o_req_valid,
  input  logic             i_req_ready,
  output logic [47:0]      o_req_sha,
  output logic [31:0]      o_req_spa,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_ovf_cnt
);

  arp_state_e r_state;
  arp_state_e w_state_nxt;

  logic [2:0] r_widx;
  logic       r_bad;
  logic       r_is_req;
  logic       r_tpa_hit;
  arp_req_t   r_shadow;
  arp_req_t   r_slot;
  logic       r_req_valid;

  logic w_beat;
  logic w_last;
  logic w_hdr_err;
  logic w_runt;
  logic w_bad_now;
  logic w_tpa_now;
  logic w_emit;
  logic w_drain;
  logic w_load;
  logic w_err_inc;
  logic w_ovf_inc;

  assign w_beat = i_arp_valid;
  assign w_last = i_arp_valid & i_arp_last;

  always_comb begin
    w_hdr_err = 1'b0;
    if (w_beat && (r_state == S_HDR)) begin
      if (r_widx == WIDX_W0) begin
        w_hdr_err = !arp_w0_ok(i_arp_data);
      end else if (r_widx == WIDX_W1) begin
        w_hdr_err = !arp_w1_ok(i_arp_data);
      end
    end
  end

  assign w_runt    = w_last && (r_widx < WIDX_TPA);
  assign w_bad_now = r_bad | w_hdr_err | w_runt;

  // TPA may arrive on the deciding beat itself, so use the live compare there
  assign w_tpa_now = (w_beat && (r_state == S_BODY) && (r_widx == WIDX_TPA)) ?
                     (i_arp_data == LOCAL_IP) : r_tpa_hit;

  assign w_emit    = w_last & ~w_bad_now & r_is_req & w_tpa_now;
  assign w_err_inc = w_last & w_bad_now;
  assign w_drain   = r_req_valid & i_req_ready;
  assign w_load    = w_emit & (~r_req_valid | i_req_ready);
  assign w_ovf_inc = w_emit & ~w_load;

  always_comb begin
    w_state_nxt = r_state;
    if (w_beat) begin
      case (r_state)
        S_HDR: begin
          if (w_last) begin
            w_state_nxt = S_HDR;
          end else if (w_bad_now) begin
            w_state_nxt = S_PAD;
          end else if (r_widx == WIDX_W1) begin
            w_state_nxt = S_BODY;
          end
        end
        S_BODY: begin
          if (w_last) begin
            w_state_nxt = S_HDR;
          end else if (r_widx == WIDX_TPA) begin
            w_state_nxt = S_PAD;
          end
        end
        S_PAD: begin
          if (w_last) begin
            w_state_nxt = S_HDR;
          end
        end
        default: w_state_nxt = S_HDR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_HDR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_widx    <= '0;
      r_bad     <= 1'b0;
      r_is_req  <= 1'b0;
      r_tpa_hit <= 1'b0;
    end else if (w_beat) begin
      if (w_last) begin
        r_widx    <= '0;
        r_bad     <= 1'b0;
        r_is_req  <= 1'b0;
        r_tpa_hit <= 1'b0;
      end else begin
        if (r_widx != WIDX_MAX) begin
          r_widx <= r_widx + 3'd1;
        end
        r_bad     <= w_bad_now;
        r_tpa_hit <= w_tpa_now;
        if ((r_state == S_HDR) && (r_widx == WIDX_W1)) begin
          r_is_req <= (i_arp_data[15:0] == ARP_OP_REQ);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (w_beat && (r_state == S_BODY)) begin
      case (r_widx)
        WIDX_SHA_HI: r_shadow.sha[47:16] <= i_arp_data;
        WIDX_MID: begin
          r_shadow.sha[15:0]  <= i_arp_data[31:16];
          r_shadow.spa[31:16] <= i_arp_data[15:0];
        end
        WIDX_SPA_LO: r_shadow.spa[15:0] <= i_arp_data[31:16];
        default: ;
      endcase
    end
  end

  // A drain and a load on the same edge keep the slot full with the new record
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot      <= '0;
      r_req_valid <= 1'b0;
    end else if (w_load) begin
      r_slot      <= r_shadow;
      r_req_valid <= 1'b1;
    end else if (w_drain) begin
      r_req_valid <= 1'b0;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_err_inc),
    .o_cnt (o_err_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_ovf_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_ovf_inc),
    .o_cnt (o_ovf_cnt)
  );

  assign o_req_valid = r_req_valid;
  assign o_req_sha   = r_slot.sha;
  assign o_req_spa   = r_slot.spa;

endmodule

// File: tb/tb_arp_rx_parser.sv
// Bench for arp_rx_parser: directed scenarios plus randomized frames against a queue-based model.
module tb_arp_rx_parser;

  localparam logic [31:0] LIP  = 32'hC0A8_010A;
  localparam int          CW   = 3;
  localparam int          CMAX = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   i_arp_data;
  logic          i_arp_valid;
  logic          i_arp_last;
  logic          o_req_valid;
  logic          i_req_ready;
  logic [47:0]   o_req_sha;
  logic [31:0]   o_req_spa;
  logic [CW-1:0] o_err_cnt;
  logic [CW-1:0] o_ovf_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: whole-frame view, decided when the last word arrives
  logic [31:0] m_frame[$];
  bit          m_valid;
  logic [47:0] m_sha;
  logic [31:0] m_spa;
  int          m_err;
  int          m_ovf;

  logic [31:0] fw[16];
  int          flen;

  arp_rx_parser #(
    .LOCAL_IP (LIP),
    .CNT_W    (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_arp_data  (i_arp_data),
    .i_arp_valid (i_arp_valid),
    .i_arp_last  (i_arp_last),
    .o_req_valid (o_req_valid),
    .i_req_ready (i_req_ready),
    .o_req_sha   (o_req_sha),
    .o_req_spa   (o_req_spa),
    .o_err_cnt   (o_err_cnt),
    .o_ovf_cnt   (o_ovf_cnt)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_frame.delete();
    m_valid = 0;
    m_sha   = '0;
    m_spa   = '0;
    m_err   = 0;
    m_ovf   = 0;
  endfunction

  function automatic void model_edge(input bit v, input bit l, input logic [31:0] d,
                                     input bit rdy);
    bit drained, bad_f, emit;
    drained = m_valid && rdy;
    emit    = 0;
    if (v) begin
      m_frame.push_back(d);
      if (l) begin
        bad_f = (m_frame.size() < 7);
        if (!bad_f) bad_f = (m_frame[0] != 32'h0001_0800) || (m_frame[1][31:16] != 16'h0604);
        if (!bad_f) emit = (m_frame[1][15:0] == 16'h0001) && (m_frame[6] == LIP);
        if (bad_f && m_err < CMAX) m_err++;
        if (emit) begin
          if (!m_valid || rdy) begin
            m_valid = 1;
            m_sha   = {m_frame[2], m_frame[3][31:16]};
            m_spa   = {m_frame[3][15:0], m_frame[4][31:16]};
          end else if (m_ovf < CMAX) begin
            m_ovf++;
          end
        end
        m_frame.delete();
      end
    end
    if (!emit && drained) m_valid = 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge(i_arp_valid, i_arp_last, i_arp_data, i_req_ready);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input bit l);
    i_arp_valid = 1'b1;
    i_arp_data  = d;
    i_arp_last  = l;
    tick();
    i_arp_valid = 1'b0;
    i_arp_last  = 1'b0;
    i_arp_data  = $urandom;
  endtask

  task automatic build(input logic [47:0] sha, input logic [31:0] spa, input logic [15:0] oper,
                       input logic [31:0] tpa, input int len);
    logic [47:0] tha;
    tha   = {16'($urandom), 32'($urandom)};
    fw[0] = 32'h0001_0800;
    fw[1] = {16'h0604, oper};
    fw[2] = sha[47:16];
    fw[3] = {sha[15:0], spa[31:16]};
    fw[4] = {spa[15:0], tha[47:32]};
    fw[5] = tha[31:0];
    fw[6] = tpa;
    for (int i = 7; i < 16; i++) fw[i] = $urandom;
    flen = len;
  endtask

  // gap_a/gap_b: insert one idle cycle after that beat index (-1 for none)
  task automatic send(input int gap_a, input int gap_b);
    for (int i = 0; i < flen; i++) begin
      beat(fw[i], i == flen - 1);
      if (i == gap_a || i == gap_b) tick();
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    i_arp_valid = 1'b0;
    i_arp_last  = 1'b0;
    i_arp_data  = '0;
    i_req_ready = 1'b0;
    model_reset();
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    i_arp_valid = 1'b0;
    i_arp_last  = 1'b0;
    i_arp_data  = '0;
    i_req_ready = 1'b0;
    model_reset();
    #12;
    total++;
    if (o_req_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %b want 0", o_req_valid);
    end
    total++;
    if (o_req_sha !== 48'h0 || o_req_spa !== 32'h0) begin
      bad++; $display("FAIL reset_data: got %h/%h want 0/0", o_req_sha, o_req_spa);
    end
    total++;
    if (o_err_cnt !== 3'd0 || o_ovf_cnt !== 3'd0) begin
      bad++; $display("FAIL reset_cnt: got err=%0d ovf=%0d want 0/0", o_err_cnt, o_ovf_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_valid_req();
    i_req_ready = 1'b0;
    build(48'h0200_0000_0001, 32'hC0A8_0102, 16'h0001, LIP, 7);
    for (int i = 0; i < 6; i++) beat(fw[i], 1'b0);
    total++;
    if (o_req_valid !== 1'b0) begin
      bad++; $display("FAIL req_early: got valid=%b want 0", o_req_valid);
    end
    beat(fw[6], 1'b1);
    total++;
    if (o_req_valid !== 1'b1) begin
      bad++; $display("FAIL req_latency: got valid=%b want 1", o_req_valid);
    end
    total++;
    if (o_req_sha !== 48'h0200_0000_0001 || o_req_spa !== 32'hC0A8_0102) begin
      bad++; $display("FAIL req_data: got %h/%h want 020000000001/c0a80102", o_req_sha, o_req_spa);
    end
    total++;
    if (o_err_cnt !== 3'd0 || o_ovf_cnt !== 3'd0) begin
      bad++; $display("FAIL req_cnt: got err=%0d ovf=%0d want 0/0", o_err_cnt, o_ovf_cnt);
    end
    i_req_ready = 1'b1;
    tick();
    i_req_ready = 1'b0;
    total++;
    if (o_req_valid !== 1'b0) begin
      bad++; $display("FAIL req_drain: got valid=%b want 0", o_req_valid);
    end
  endtask

  task automatic test_padded_hold();
    i_req_ready = 1'b0;
    build(48'h0200_0000_0001, 32'hC0A8_0102, 16'h0001, LIP, 12);
    send(2, 4);
    for (int k = 0; k < 5; k++) begin
      total++;
      if (o_req_valid !== 1'b1 || o_req_sha !== 48'h0200_0000_0001 ||
          o_req_spa !== 32'hC0A8_0102) begin
        bad++;
        $display("FAIL hold_cycle%0d: got v=%b %h/%h want 1 020000000001/c0a80102", k,
                 o_req_valid, o_req_sha, o_req_spa);
      end
      tick();
    end
    i_req_ready = 1'b1;
    tick();
    i_req_ready = 1'b0;
    total++;
    if (o_req_valid !== 1'b0) begin
      bad++; $display("FAIL hold_drop: got valid=%b want 0", o_req_valid);
    end
  endtask

  task automatic test_ignored();
    i_req_ready = 1'b0;
    build({16'($urandom), 32'($urandom)}, $urandom, 16'h0002, LIP, 7);
    send(-1, -1);
    tick();
    total++;
    if (o_req_valid !== 1'b0 || o_err_cnt !== 3'd0) begin
      bad++; $display("FAIL reply_ignored: got v=%b err=%0d want 0/0", o_req_valid, o_err_cnt);
    end
    build({16'($urandom), 32'($urandom)}, $urandom, 16'h0001, 32'hC0A8_0199, 9);
    send(3, -1);
    tick();
    total++;
    if (o_req_valid !== 1'b0 || o_err_cnt !== 3'd0) begin
      bad++; $display("FAIL tpa_ignored: got v=%b err=%0d want 0/0", o_req_valid, o_err_cnt);
    end
  endtask

  task automatic test_errors();
    i_req_ready = 1'b0;
    build({16'($urandom), 32'($urandom)}, $urandom, 16'h0001, LIP, 7);
    fw[0] = 32'h0006_0800;
    send(-1, -1);
    build({16'($urandom), 32'($urandom)}, $urandom, 16'h0001, LIP, 4);
    send(-1, -1);
    build({16'($urandom), 32'($urandom)}, $urandom, 16'h0001, LIP, 7);
    fw[1] = 32'h0804_0001;
    send(-1, -1);
    total++;
    if (o_err_cnt !== 3'd3 || o_req_valid !== 1'b0) begin
      bad++; $display("FAIL err_count: got err=%0d v=%b want 3/0", o_err_cnt, o_req_valid);
    end
    build({16'($urandom), 32'($urandom)}, $urandom, 16'h0001, LIP, 8);
    send(-1, -1);
    total++;
    if (o_req_valid !== 1'b1 || o_req_sha !== m_sha || o_req_spa !== m_spa) begin
      bad++; $display("FAIL err_recover: got v=%b %h/%h want 1 %h/%h", o_req_valid, o_req_sha,
                      o_req_spa, m_sha, m_spa);
    end
    i_req_ready = 1'b1;
    tick();
    i_req_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [47:0] sha_a, sha_b;
    i_req_ready = 1'b0;
    sha_a = {16'($urandom), 32'($urandom)};
    sha_b = {16'($urandom), 32'($urandom)};
    build(sha_a, $urandom, 16'h0001, LIP, 7);
    send(-1, -1);
    build(sha_b, $urandom, 16'h0001, LIP, 7);
    send(-1, -1);
    total++;
    if (o_req_valid !== 1'b1 || o_req_sha !== sha_a || o_ovf_cnt !== 3'd1) begin
      bad++; $display("FAIL b2b_drop: got v=%b sha=%h ovf=%0d want 1 %h 1", o_req_valid,
                      o_req_sha, o_ovf_cnt, sha_a);
    end
    i_req_ready = 1'b1;
    tick();
    i_req_ready = 1'b0;
    build(sha_a, $urandom, 16'h0001, LIP, 7);
    send(-1, -1);
    build(sha_b, $urandom, 16'h0001, LIP, 7);
    for (int i = 0; i < 6; i++) beat(fw[i], 1'b0);
    i_req_ready = 1'b1;
    beat(fw[6], 1'b1);
    i_req_ready = 1'b0;
    total++;
    if (o_req_valid !== 1'b1 || o_req_sha !== sha_b || o_req_spa !== m_spa ||
        o_ovf_cnt !== 3'd1) begin
      bad++; $display("FAIL b2b_reload: got v=%b sha=%h ovf=%0d want 1 %h 1", o_req_valid,
                      o_req_sha, o_ovf_cnt, sha_b);
    end
    i_req_ready = 1'b1;
    tick();
    i_req_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    i_req_ready = 1'b0;
    build({16'($urandom), 32'($urandom)}, $urandom, 16'h0001, LIP, 7);
    send(-1, -1);
    build({16'($urandom), 32'($urandom)}, $urandom, 16'h0001, LIP, 3);
    send(-1, -1);
    build({16'($urandom), 32'($urandom)}, $urandom, 16'h0001, LIP, 7);
    for (int i = 0; i < 4; i++) beat(fw[i], 1'b0);
    i_arp_valid = 1'b1;
    i_arp_data  = fw[4];
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    i_arp_valid = 1'b0;
    total++;
    if (o_req_valid !== 1'b0 || o_req_sha !== 48'h0 || o_req_spa !== 32'h0 ||
        o_err_cnt !== 3'd0 || o_ovf_cnt !== 3'd0) begin
      bad++; $display("FAIL midrst_clear: got v=%b %h/%h err=%0d ovf=%0d want all 0",
                      o_req_valid, o_req_sha, o_req_spa, o_err_cnt, o_ovf_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    build({16'($urandom), 32'($urandom)}, $urandom, 16'h0001, LIP, 7);
    send(-1, -1);
    total++;
    if (o_req_valid !== 1'b1 || o_req_sha !== {fw[2], fw[3][31:16]} ||
        o_req_spa !== {fw[3][15:0], fw[4][31:16]} || o_err_cnt !== 3'd0) begin
      bad++; $display("FAIL midrst_next: got v=%b %h/%h err=%0d want 1 %h/%h 0", o_req_valid,
                      o_req_sha, o_req_spa, o_err_cnt, m_sha, m_spa);
    end
    i_req_ready = 1'b1;
    tick();
    i_req_ready = 1'b0;
  endtask

  task automatic test_random();
    int kind, i;
    logic [31:0] msk;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 5);
      build({16'($urandom), 32'($urandom)}, $urandom,
            (kind == 3) ? 16'h0002 : 16'h0001,
            (kind == 4) ? (LIP ^ (32'h1 << $urandom_range(0, 31))) : LIP,
            $urandom_range(7, 12));
      if (kind == 5) begin
        case ($urandom_range(0, 2))
          0: begin msk = 32'h1 << $urandom_range(0, 31); fw[0] = fw[0] ^ msk; end
          1: begin msk = 32'h1 << $urandom_range(16, 31); fw[1] = fw[1] ^ msk; end
          default: flen = $urandom_range(1, 6);
        endcase
      end
      i = 0;
      while (i < flen) begin
        i_req_ready = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) begin
          tick();
        end else begin
          beat(fw[i], i == flen - 1);
          i++;
        end
        total++;
        if (o_req_valid !== m_valid) begin
          bad++; $display("FAIL rnd_valid f%0d: got %b want %b", n, o_req_valid, m_valid);
        end
        if (m_valid) begin
          total++;
          if (o_req_sha !== m_sha || o_req_spa !== m_spa) begin
            bad++; $display("FAIL rnd_data f%0d: got %h/%h want %h/%h", n, o_req_sha,
                            o_req_spa, m_sha, m_spa);
          end
        end
        total++;
        if (o_err_cnt !== 3'(m_err) || o_ovf_cnt !== 3'(m_ovf)) begin
          bad++; $display("FAIL rnd_cnt f%0d: got err=%0d ovf=%0d want %0d/%0d", n, o_err_cnt,
                          o_ovf_cnt, m_err, m_ovf);
        end
      end
    end
    i_req_ready = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int n = 0; n < 11; n++) begin
      build({16'($urandom), 32'($urandom)}, $urandom, 16'h0001, LIP, 7);
      fw[0] = 32'h0001_0806;
      send(-1, -1);
    end
    total++;
    if (o_err_cnt !== 3'd7 || o_err_cnt !== 3'(m_err)) begin
      bad++; $display("FAIL err_saturate: got %0d want 7", o_err_cnt);
    end
    i_req_ready = 1'b0;
    for (int n = 0; n < 10; n++) begin
      build({16'($urandom), 32'($urandom)}, $urandom, 16'h0001, LIP, 7);
      send(-1, -1);
    end
    total++;
    if (o_ovf_cnt !== 3'd7 || o_err_cnt !== 3'd7) begin
      bad++; $display("FAIL ovf_saturate: got ovf=%0d err=%0d want 7/7", o_ovf_cnt, o_err_cnt);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_valid_req();
    test_padded_hold();
    test_ignored();
    test_errors();
    test_back_to_back();
    test_mid_reset();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
